// File: rtl/serial_alu.sv
// -----------------------------------------------------------------------------
// serial_alu
//
// Bit-serial WIDTH-bit ALU sequencer. A full-width request is latched on
// start, then evaluated one bit per clock (LSB first) through a single 1-bit
// slice: a full adder with a registered carry, plus a 2-input logic unit.
// When the last bit has been processed the full-width result and flags are
// published and `done` pulses for one cycle.
//
// Parameters
//   WIDTH     operand / result width, legal range 2..64
//
// Ports
//   clock     system clock, all state changes on the rising edge
//   reset     synchronous, active-high
//   start     operation request, only sampled in IDLE
//   A, B      operands, latched when start is accepted
//   control   opcode, latched when start is accepted
//               control[2] = 0 : arithmetic, control[0] selects subtract
//               control[2] = 1 : logic, control[1:0] = AND/OR/NOR/XOR
//   busy      high while bits are being processed
//   done      one-cycle completion pulse
//   out       result, held until the next completion
//   carryout  carry out of the MSB (arithmetic only, else 0)
//   overflow  signed overflow (arithmetic only, else 0)
//   zero      high when out is 0
// -----------------------------------------------------------------------------
module serial_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned    CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Sequencing and latched operands. The operand copies are shifted right
    // each RUN cycle so the slice always reads bit 0; count only decides
    // when the last bit is being processed.
    logic [CW-1:0]    count;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       ctrl_q;
    logic [WIDTH-1:0] res_q;

    // 1-bit slice
    logic             a_bit;
    logic             b_bit;
    logic             b_eff;
    logic             sum_bit;
    logic             carry_next;
    logic             logic_bit;
    logic             res_bit;
    logic             is_arith;
    logic             last_bit;
    logic [WIDTH-1:0] res_final;

    always_comb begin
        a_bit      = a_q[0];
        b_bit      = b_q[0];
        is_arith   = ~ctrl_q[2];
        b_eff      = b_bit ^ ctrl_q[0];
        sum_bit    = a_bit ^ b_eff ^ carry;
        carry_next = (a_bit & b_eff) | ((a_bit ^ b_eff) & carry);

        logic_bit = 1'b0;
        case (ctrl_q[1:0])
            2'b00:   logic_bit = a_bit & b_bit;
            2'b01:   logic_bit = a_bit | b_bit;
            2'b10:   logic_bit = ~(a_bit | b_bit);
            default: logic_bit = a_bit ^ b_bit;
        endcase

        res_bit   = is_arith ? sum_bit : logic_bit;
        // Result bits enter at the MSB end; after WIDTH shifts bit 0 of the
        // operation has arrived at bit 0 of the register.
        res_final = {res_bit, res_q[WIDTH-1:1]};
        last_bit  = (count == LAST);
    end

    // Next-state logic and state-derived outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            carry    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            res_q    <= '0;
            out      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= A;
                        b_q    <= B;
                        ctrl_q <= control;
                        count  <= '0;
                        carry  <= control[0];
                        res_q  <= '0;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_final;
                    carry <= carry_next;
                    count <= count + CW'(1);
                    if (last_bit) begin
                        // carry holds the carry into the MSB at this point,
                        // carry_next the carry out of it.
                        out      <= res_final;
                        carryout <= is_arith & carry_next;
                        overflow <= is_arith & (carry ^ carry_next);
                        zero     <= (res_final == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
module tb_serial_alu;

    localparam int unsigned WIDTH = 32;

    logic             clock;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       control;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             carryout;
    logic             overflow;
    logic             zero;

    int checks;
    int errors;

    // Last result the bench expects `out` to be holding.
    logic [WIDTH-1:0] last_res;

    // Working variables for the inline steps
    logic [WIDTH-1:0] er;
    logic             eco;
    logic             eov;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] ca;
    logic [WIDTH-1:0] cb;
    logic [WIDTH-1:0] acc_a;
    logic [WIDTH-1:0] acc_b;
    logic [2:0]       rc;
    logic             pbusy;
    int               accepts;
    int               ndone;
    int               acc_edge0;
    int               acc_edge1;
    int               waited;

    serial_alu #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .A        (A),
        .B        (B),
        .control  (control),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .carryout (carryout),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic on the operands.
    function automatic void model(input logic [2:0] c, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] r,
                                  output logic co, output logic ov);
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] bb;
        if (!c[2]) begin
            bb = c[0] ? ~b : b;
            s  = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(c[0]);
            r  = s[WIDTH-1:0];
            co = s[WIDTH];
            ov = (a[WIDTH-1] == bb[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        end else begin
            case (c[1:0])
                2'b00:   r = a & b;
                2'b01:   r = a | b;
                2'b10:   r = ~(a | b);
                default: r = a ^ b;
            endcase
            co = 1'b0;
            ov = 1'b0;
        end
    endfunction

    // Issue one request from IDLE and check timing, result, flags and the
    // return to IDLE. Operand inputs are scrambled right after acceptance.
    task automatic run_op(input logic [2:0] c, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input string tag);
        logic [WIDTH-1:0] xr;
        logic             xco;
        logic             xov;
        int               lat;
        int               busy_cnt;
        model(c, a, b, xr, xco, xov);
        @(negedge clock);
        A = a; B = b; control = c; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        A = $urandom; B = $urandom; control = 3'($urandom);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat <= int'(WIDTH) + 4) begin
            if (busy) busy_cnt++;
            if (lat == int'(WIDTH) / 2) chk({tag, ".hold"}, out, last_res);
            @(posedge clock); #1;
            lat++;
        end
        chk({tag, ".done_lat"}, lat, WIDTH);
        chk({tag, ".busy_cnt"}, busy_cnt, WIDTH);
        chk({tag, ".out"}, out, xr);
        chk({tag, ".carryout"}, carryout, xco);
        chk({tag, ".overflow"}, overflow, xov);
        chk({tag, ".zero"}, zero, (xr == '0));
        last_res = xr;
        @(posedge clock); #1;
        chk({tag, ".idle_done"}, done, 1'b0);
        chk({tag, ".idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        A        = '0;
        B        = '0;
        control  = '0;
        last_res = '0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.out", out, 0);
        chk("rst.carryout", carryout, 1'b0);
        chk("rst.overflow", overflow, 1'b0);
        chk("rst.zero", zero, 1'b1);
        @(negedge clock);
        reset = 1'b0;

        // Directed cases
        run_op(3'd2, 32'd5, 32'd3, "add_5_3");
        chk("add_5_3.const", out, 32'h0000_0008);
        run_op(3'd3, 32'd3, 32'd5, "sub_3_5");
        chk("sub_3_5.const", out, 32'hFFFF_FFFE);
        run_op(3'd3, 32'd5, 32'd3, "sub_5_3");
        run_op(3'd3, 32'h1234, 32'h1234, "sub_eq");
        run_op(3'd2, 32'h7FFF_FFFF, 32'd1, "add_ovf");
        chk("add_ovf.const", overflow, 1'b1);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd1, "add_wrap");
        run_op(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, "and");
        run_op(3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, "or");
        run_op(3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, "nor");
        chk("nor.const", out, 32'h000F_000F);
        run_op(3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, "xor");
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, "op0_add");
        run_op(3'd1, 32'h8000_0000, 32'd1, "op1_sub");

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            rc = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ((i % 6) == 0) ? ra : $urandom;
            run_op(rc, ra, rb, $sformatf("rand%0d", i));
        end

        // start held high with operands changing every cycle: only the
        // operands present at an IDLE edge are used.
        accepts   = 0;
        ndone     = 0;
        acc_edge0 = -1;
        acc_edge1 = -1;
        pbusy     = 1'b0;
        acc_a     = '0;
        acc_b     = '0;
        control   = 3'd2;
        for (int e = 0; e < 2 * (int'(WIDTH) + 2); e++) begin
            @(negedge clock);
            ca = $urandom; cb = $urandom;
            A = ca; B = cb; start = 1'b1;
            @(posedge clock); #1;
            if (busy && !pbusy) begin
                acc_a = ca;
                acc_b = cb;
                if (accepts == 0) acc_edge0 = e;
                if (accepts == 1) acc_edge1 = e;
                accepts++;
            end
            if (done) begin
                model(3'd2, acc_a, acc_b, er, eco, eov);
                chk($sformatf("held.out%0d", ndone), out, er);
                chk($sformatf("held.co%0d", ndone), carryout, eco);
                last_res = er;
                ndone++;
            end
            pbusy = busy;
        end
        start = 1'b0;
        chk("held.accepts", accepts, 2);
        chk("held.dones", ndone, 2);
        chk("held.spacing", acc_edge1 - acc_edge0, WIDTH + 2);

        // start asserted while in DONE is dropped
        ra = $urandom; rb = $urandom;
        model(3'd7, ra, rb, er, eco, eov);
        @(negedge clock);
        A = ra; B = rb; control = 3'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        waited = 0;
        while (!done && waited < int'(WIDTH) + 4) begin
            @(posedge clock); #1;
            waited++;
        end
        chk("done_start.reached", done, 1'b1);
        @(negedge clock);
        A = $urandom; B = $urandom; control = 3'd2; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("done_start.busy", busy, 1'b0);
        waited = 0;
        for (int e = 0; e < int'(WIDTH) + 4; e++) begin
            @(posedge clock); #1;
            if (busy || done) waited++;
        end
        chk("done_start.no_activity", waited, 0);
        chk("done_start.out", out, er);
        last_res = er;

        // Reset during RUN aborts the operation
        @(negedge clock);
        A = 32'h1357_9BDF; B = 32'h0246_8ACE; control = 3'd2; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort.busy", busy, 1'b0);
        chk("abort.done", done, 1'b0);
        chk("abort.out", out, 0);
        chk("abort.zero", zero, 1'b1);
        chk("abort.carryout", carryout, 1'b0);
        chk("abort.overflow", overflow, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        last_res = '0;
        waited = 0;
        for (int e = 0; e < int'(WIDTH) + 4; e++) begin
            @(posedge clock); #1;
            if (done) waited++;
        end
        chk("abort.no_done", waited, 0);
        run_op(3'd2, 32'd1, 32'd1, "after_abort");
        chk("after_abort.const", out, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_alu.md
# serial_alu

Bit-serial WIDTH-bit ALU sequencer. It accepts a full-width operation request, then evaluates it one bit per cycle, LSB first, through a single 1-bit ALU slice datapath (full adder plus logic unit) with a registered carry. Once all bits are done it presents the full-width result and flags with a one-cycle `done` pulse. It sits beside the parallel ALU as the low-area execution option and drives the slice interface from the operand/sequencing side.

## Interface
- `WIDTH`, default 32: operand and result width in bits; legal range 2..64.

- `clock`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `start`  in  1  request; sampled only in IDLE.
- `A`  in  WIDTH  operand A, captured when `start` is accepted.
- `B`  in  WIDTH  operand B, captured when `start` is accepted.
- `control`  in  3  operation code, captured when `start` is accepted.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse in the DONE state.
- `out`  out  WIDTH  result; holds its value until the next completion.
- `carryout`  out  1  carry out of the MSB; arithmetic only, 0 for logic ops.
- `overflow`  out  1  signed overflow; arithmetic only, 0 for logic ops.
- `zero`  out  1  high when `out` is 0.

## Operation
- Opcodes: 2 = ADD, 3 = SUB, 4 = AND, 5 = OR, 6 = NOR, 7 = XOR.
  - `control[2]` = 0 selects arithmetic and `control[0]` selects subtract. Codes 0 and 1 therefore behave as ADD and SUB.
  - Logic ops use `control[1:0]`: 00 AND, 01 OR, 10 NOR, 11 XOR.
- Per bit i:
  - b = B[i] XOR `control[0]`.
  - sum = A[i] ^ b ^ c; next c = (A[i]&b) | ((A[i]^b)&c).
  - The result bit is sum for arithmetic, or the logic function of A[i], B[i] for logic ops.
- Initial carry c = `control[0]`, so SUB computes A + ~B + 1.
- State machine (IDLE, RUN, DONE):
  - IDLE → RUN when `start` = 1:
    - latch A, B, `control`;
    - set bit counter to 0;
    - set carry to `control[0]`.
  - RUN: on each edge, process bit `count`, shift the result bit into the internal result register at the MSB end (right shift), and increment `count`.
  - RUN → DONE on the edge that processes bit WIDTH-1. On that same edge:
    - `out` ← final result;
    - `carryout` ← final carry (arithmetic) else 0;
    - `overflow` ← carry into MSB XOR carry out of MSB (arithmetic) else 0;
    - `zero` ← (final result == 0).
  - DONE → IDLE unconditionally after one cycle.
- `start` is ignored in RUN and DONE. It is not queued, so a request made during DONE is lost.
- Operand inputs may change freely after acceptance. Only the latched copies are used.
- `out`, `carryout`, `overflow` and `zero` update only on the RUN → DONE edge. They are stable at all other times.

## Timing
- Reset:
  - state = IDLE, `busy` = 0, `done` = 0;
  - `out` = 0, `carryout` = 0, `overflow` = 0;
  - `zero` = 1, consistent with `out` = 0;
  - counter, carry and latched operands are all 0.
- `reset` asserted in RUN or DONE aborts the operation. State is IDLE after that edge, no `done` pulse is produced, and the outputs take their reset values.
- Reset has priority over `start` on the same edge.
- `start` sampled high in IDLE at edge k:
  - `busy` = 1 during cycles k+1 … k+WIDTH;
  - `done` = 1 and result valid during cycle k+WIDTH+1;
  - IDLE again in cycle k+WIDTH+2. `start` is accepted at the earliest at edge k+WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles.
- Counter width is clog2(WIDTH)+1. The counter never wraps because the FSM leaves RUN at `count` = WIDTH-1.

## Test plan
- ADD, WIDTH=32, A=5, B=3:
  - `out`=0x00000008, `carryout`=0, `overflow`=0, `zero`=0;
  - `done` exactly 33 cycles after the start edge;
  - `busy` high for exactly 32 cycles.
- SUB:
  - A=3, B=5 → `out`=0xFFFFFFFE, `carryout`=0, `overflow`=0.
  - A=5, B=3 → `out`=2, `carryout`=1.
  - A=B=0x1234 → `zero`=1, `carryout`=1.
- Overflow:
  - ADD 0x7FFFFFFF + 1 → `out`=0x80000000, `overflow`=1, `carryout`=0.
  - ADD 0xFFFFFFFF + 1 → `out`=0, `carryout`=1, `overflow`=0, `zero`=1.
- Logic ops, A=0xF0F0F0F0, B=0xFF00FF00:
  - AND → 0xF000F000; OR → 0xFFF0FFF0; NOR → 0x000F000F; XOR → 0x0FF00FF0.
  - `carryout`=0 and `overflow`=0 for all four.
- Handshake:
  - `start` held high continuously with changing A/B → only requests sampled in IDLE are executed; the result matches the operands latched at acceptance.
  - `start` during DONE → ignored.
- Reset mid-op:
  - assert `reset` at RUN bit 10 → no `done` pulse, `out`=0, `zero`=1, `busy`=0 the next cycle;
  - a subsequent ADD 1+1 then completes correctly with `out`=2.
